rsa_job_arbiter: RTL and testbench

- Shares one RSA_decrypt engine (16-bit c/d/n, start pulse, finish strobe) between NREQ requesters using round-robin grant and valid/ready handshakes.
- Measures engine latency per job, which is the timing side-channel observable.
- Optional constant-time mode pads every job's response to a fixed cycle count.
- Recovers a hung engine by timeout and flush.
- Sits between software-facing request ports and the single engine instance.

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/rsa_job_arbiter_rr.sv | 40 ++++
 rtl/rsa_job_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rsa_job_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types and default constants for the RSA job arbiter.
//   state_t         job FSM state encoding
//   *_DEF           default operand width, latency counter width,
//                   hang timeout and constant-time padding length
package rsa_pkg;

  localparam int W_DEF          = 16;
  localparam int CNT_W_DEF      = 24;
  localparam int TIMEOUT_DEF    = 1000000;
  localparam int PAD_CYCLES_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    BUSY,
    PAD,
    RESP
  } state_t;

endpackage

// File: rtl/rsa_job_arbiter_rr.sv
// rr_arbiter: purely combinational round-robin grant.
//   req         request vector, one bit per requester
//   last_grant  index of the requester served most recently
//   grant       one-hot winner (zero when nobody requests)
//   grant_idx   binary index of the winner (zero when nobody requests)
// The search starts at last_grant+1 modulo NREQ and takes the first
// requester that is asking.
module rr_arbiter
  import rsa_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W-1:0] sel;

  // NOTE: every variable written here gets a value before any branch,
  // otherwise the tool infers a latch to hold it on the untaken paths.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sel       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sel = IDX_W'((int'(last_grant) + k) % NREQ);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// rsa_job_arbiter: shares one RSA decrypt engine between NREQ requesters.
//   clk, rst                    clock and synchronous active-high reset
//   req_valid/req_ready         per-requester request handshake
//   req_c/req_d/req_n           flattened operands, requester i at [i*W +: W]
//   ct_mode                     constant-time enable, sampled at grant
//   resp_valid/resp_ready       one-hot response handshake to the granted requester
//   resp_m/resp_cycles/resp_err result, measured engine latency, timeout flag
//   eng_start, eng_c/d/n        engine start pulse and operands
//   eng_m, eng_finish           engine result and done strobe
//   eng_flush                   one-cycle engine reset request after a timeout
module rsa_job_arbiter
  import rsa_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int NREQ       = 2,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int PAD_CYCLES = PAD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_c,
  input  logic [NREQ*W-1:0] req_d,
  input  logic [NREQ*W-1:0] req_n,
  input  logic              ct_mode,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [W-1:0]      resp_m,
  output logic [CNT_W-1:0]  resp_cycles,
  output logic              resp_err,
  output logic              eng_start,
  output logic [W-1:0]      eng_c,
  output logic [W-1:0]      eng_d,
  output logic [W-1:0]      eng_n,
  input  logic [W-1:0]      eng_m,
  input  logic              eng_finish,
  output logic              eng_flush
);

  localparam int               IDX_W     = $clog2(NREQ);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PAD_C     = CNT_W'(PAD_CYCLES);

  state_t           state, state_next;
  logic [NREQ-1:0]  grant_oh;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] gnt;
  logic             ct_lat;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] cnt_inc;
  logic [W-1:0]     sel_c, sel_d, sel_n;
  logic             accept, finish_hit, timeout_hit, resp_hs;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant_oh),
    .grant_idx  (grant_idx)
  );

  // Only the round-robin winner sees ready, and only while idle.
  assign req_ready  = (state == IDLE) ? grant_oh : '0;
  assign resp_valid = (state == RESP) ? (NREQ'(1) << gnt) : '0;

  assign accept      = |(req_valid & req_ready);
  assign resp_hs     = (state == RESP) && resp_ready[gnt];
  assign cnt_inc     = (counter == CNT_MAX) ? counter : counter + 1'b1;
  assign finish_hit  = (state == BUSY) && eng_finish;
  // A finish in the same cycle as the timeout takes priority.
  assign timeout_hit = (state == BUSY) && !eng_finish && (cnt_inc == TIMEOUT_C);

  always_comb begin
    sel_c = '0;
    sel_d = '0;
    sel_n = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        sel_c = req_c[i*W +: W];
        sel_d = req_d[i*W +: W];
        sel_n = req_n[i*W +: W];
      end
    end
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = ISSUE;
      ISSUE: state_next = BUSY;
      BUSY: begin
        if (finish_hit) state_next = (ct_lat && (cnt_inc < PAD_C)) ? PAD : RESP;
        else if (timeout_hit) state_next = RESP;
      end
      PAD:   if (cnt_inc >= PAD_C) state_next = RESP;
      RESP:  if (resp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eng_c       <= '0;
      eng_d       <= '0;
      eng_n       <= '0;
      eng_start   <= 1'b0;
      eng_flush   <= 1'b0;
      ct_lat      <= 1'b0;
      gnt         <= '0;
      last_grant  <= IDX_W'(NREQ - 1);
      counter     <= '0;
      resp_m      <= '0;
      resp_cycles <= '0;
      resp_err    <= 1'b0;
    end else begin
      // Start is registered out of ISSUE: the engine sees it two cycles after
      // accept, in the first BUSY cycle, where the counter reads 0. The value
      // captured at finish (counter+1) is thus the number of cycles from the
      // start pulse through the finish strobe inclusive.
      eng_start <= (state == ISSUE);
      eng_flush <= timeout_hit;

      if (accept) begin
        eng_c  <= sel_c;
        eng_d  <= sel_d;
        eng_n  <= sel_n;
        ct_lat <= ct_mode;
        gnt    <= grant_idx;
      end

      case (state)
        ISSUE:     counter <= '0;
        BUSY, PAD: counter <= cnt_inc;
        default:   ;
      endcase

      // resp_cycles keeps the measured latency; padding only delays resp_valid.
      if (finish_hit) begin
        resp_m      <= eng_m;
        resp_cycles <= cnt_inc;
        resp_err    <= 1'b0;
      end else if (timeout_hit) begin
        resp_m      <= '0;
        resp_cycles <= TIMEOUT_C;
        resp_err    <= 1'b1;
      end

      if (resp_hs) last_grant <= gnt;
    end
  end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// tb_rsa_job_arbiter: directed plus randomized jobs against a behavioural
// engine model and a job-level reference for grant order, latency and padding.
module tb_rsa_job_arbiter;

  localparam int W       = 16;
  localparam int NREQ    = 2;
  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 400;
  localparam int PAD     = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_c = '0, req_d = '0, req_n = '0;
  logic              ct_mode = 1'b0;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready = '0;
  logic [W-1:0]      resp_m;
  logic [CNT_W-1:0]  resp_cycles;
  logic              resp_err;
  logic              eng_start;
  logic [W-1:0]      eng_c, eng_d, eng_n;
  logic [W-1:0]      eng_m = 16'hDEAD;
  logic              eng_finish = 1'b0;
  logic              eng_flush;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Engine model configuration and observations.
  int         eng_lat = 0;     // 0: data-dependent latency, else fixed
  bit         eng_hang = 1'b0;
  bit         eng_busy = 1'b0;
  int         eng_k = 0;
  int         cur_lat = 0;
  int         start_cyc = 0;
  int         finish_cyc = 0;
  logic [W-1:0] eng_res = '0;

  // Job-level reference state.
  int           model_last = NREQ - 1;
  logic [W-1:0] op_c [NREQ];
  logic [W-1:0] op_d [NREQ];
  logic [W-1:0] op_n [NREQ];

  rsa_job_arbiter #(
    .W(W), .NREQ(NREQ), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .PAD_CYCLES(PAD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_c(req_c), .req_d(req_d), .req_n(req_n),
    .ct_mode(ct_mode),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_m(resp_m), .resp_cycles(resp_cycles), .resp_err(resp_err),
    .eng_start(eng_start), .eng_c(eng_c), .eng_d(eng_d), .eng_n(eng_n),
    .eng_m(eng_m), .eng_finish(eng_finish), .eng_flush(eng_flush)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] modexp(input logic [W-1:0] c, input logic [W-1:0] d,
                                          input logic [W-1:0] n);
    longint r, b;
    r = 1 % longint'(n);
    b = longint'(c) % longint'(n);
    for (int i = 0; i < W; i++) begin
      if (d[i]) r = (r * b) % longint'(n);
      b = (b * b) % longint'(n);
    end
    return W'(r);
  endfunction

  // Engine: square-and-multiply result, latency 8 + popcount(d) unless fixed.
  // Counts its start cycle as 1, so a latency L finishes L-1 cycles later.
  always @(negedge clk) begin
    eng_finish = 1'b0;
    eng_m      = 16'hDEAD;
    if (rst || eng_flush) begin
      eng_busy = 1'b0;
    end else begin
      if (eng_start) begin
        eng_busy  = 1'b1;
        eng_k     = 0;
        start_cyc = cyc;
        eng_res   = modexp(eng_c, eng_d, eng_n);
        cur_lat   = (eng_lat > 0) ? eng_lat : 8 + $countones(eng_d);
      end
      if (eng_busy) begin
        eng_k++;
        if (eng_k == cur_lat && !eng_hang) begin
          eng_finish = 1'b1;
          eng_m      = eng_res;
          eng_busy   = 1'b0;
          finish_cyc = cyc;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [NREQ-1:0] oh(input int g);
    return NREQ'(1) << g;
  endfunction

  // Both asking: whoever was not served last goes next; else the only asker.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    if (v == 2'b11) return (last == 0) ? 1 : 0;
    return v[1] ? 1 : 0;
  endfunction

  task automatic drive_ops();
    for (int r = 0; r < NREQ; r++) begin
      req_c[r*W +: W] = op_c[r];
      req_d[r*W +: W] = op_d[r];
      req_n[r*W +: W] = op_n[r];
    end
  endtask

  task automatic new_ops(input int r);
    op_c[r] = W'($urandom_range(0, 65535));
    op_d[r] = W'($urandom_range(0, 65535));
    op_n[r] = W'($urandom_range(2, 65535));
    drive_ops();
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({req_ready, resp_valid, resp_m, resp_cycles, resp_err,
                    eng_start, eng_flush}), 64'd0);
    check({tag, "_ops"}, 64'({eng_c, eng_d, eng_n}), 64'd0);
  endtask

  // One complete job: request, accept, issue, engine run, response, handshake.
  task automatic run_job(input logic [NREQ-1:0] vmask, input bit ct, input int lat,
                         input bit hang, input int hold, input bit keep);
    int g, n, acc, L, exp_rise, extra_start, bad_ready, early_flush;
    logic [W-1:0] c, d, nn, exp_m, m0;
    logic [CNT_W-1:0] cy0;
    bit stable;
    g  = pick(vmask, model_last);
    c  = op_c[g];
    d  = op_d[g];
    nn = op_n[g];
    eng_lat   = lat;
    eng_hang  = hang;
    ct_mode   = ct;
    req_valid = vmask;
    #1;
    n = 0;
    while (!(|(req_valid & req_ready)) && n < 20) begin
      tick();
      n++;
    end
    acc = cyc;
    check("accept_seen", 64'(n < 20), 64'd1);
    check("req_ready_winner", 64'(req_ready), 64'(oh(g)));

    tick();                                  // ISSUE cycle
    if (!keep) req_valid = '0;
    ct_mode = ~ct;                           // must have been latched at grant
    check("start_not_early", 64'(eng_start), 64'd0);
    check("ready_low_issue", 64'(req_ready), 64'd0);

    tick();                                  // two cycles after accept
    check("start_at_accept_plus2", 64'(eng_start), 64'd1);
    check("eng_operands", 64'({eng_c, eng_d, eng_n}), 64'({c, d, nn}));
    new_ops(g);

    n = 0; extra_start = 0; bad_ready = 0; early_flush = 0;
    tick();
    while (resp_valid == '0 && n < TIMEOUT + PAD + 20) begin
      if (eng_start) extra_start++;
      if (req_ready != '0) bad_ready++;
      if (eng_flush) early_flush++;
      tick();
      n++;
    end

    if (hang) begin
      L = TIMEOUT;
      exp_m = '0;
    end else begin
      L = (lat > 0) ? lat : 8 + $countones(d);
      exp_m = modexp(c, d, nn);
    end
    exp_rise = acc + 2 + ((ct && !hang && L < PAD) ? PAD : L);

    check("resp_valid_onehot", 64'(resp_valid), 64'(oh(g)));
    check("resp_rise_cycle", 64'(cyc), 64'(exp_rise));
    check("resp_m", 64'(resp_m), 64'(exp_m));
    check("resp_cycles", 64'(resp_cycles), 64'(L));
    check("resp_err", 64'(resp_err), 64'(hang));
    check("flush_first_resp", 64'(eng_flush), 64'(hang));
    check("busy_quiet", 64'({extra_start, bad_ready, early_flush}), 64'd0);
    if (!hang) check("cycles_vs_measured", 64'(resp_cycles), 64'(finish_cyc - start_cyc + 1));

    m0 = resp_m;
    cy0 = resp_cycles;
    stable = 1'b1;
    resp_ready = ~oh(g);                     // non-granted readies are ignored
    for (int i = 0; i < hold; i++) begin
      tick();
      if (resp_valid != oh(g) || resp_m != m0 || resp_cycles != cy0 ||
          resp_err != hang || req_ready != '0 || eng_start || eng_flush)
        stable = 1'b0;
    end
    check("resp_hold_stable", 64'(stable), 64'd1);

    resp_ready = oh(g);
    tick();
    resp_ready = '0;
    check("resp_released", 64'(resp_valid), 64'd0);
    check("flush_one_cycle", 64'(eng_flush), 64'd0);
    model_last = g;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    for (int r = 0; r < NREQ; r++) begin
      op_c[r] = '0;
      op_d[r] = '0;
      op_n[r] = 16'd2;
    end

    // Reset state.
    rst = 1'b1;
    tick(); tick(); tick();
    check_all_zero("reset_held");
    rst = 1'b0;
    tick();
    check_all_zero("reset_idle");

    // Known RSA job on requester 0, real data-dependent latency.
    op_c[0] = 16'd1394; op_d[0] = 16'd2011; op_n[0] = 16'd3127;
    new_ops(1);
    op_c[0] = 16'd1394; op_d[0] = 16'd2011; op_n[0] = 16'd3127;
    drive_ops();
    run_job(2'b01, 1'b0, 0, 1'b0, 0, 1'b0);
    check("rsa_known_m", 64'(resp_m), 64'd89);

    // Contention straight after reset: 0,1,0,1 with both held valid.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_last = NREQ - 1;
    new_ops(0);
    for (int j = 0; j < 4; j++) begin
      run_job(2'b11, 1'b0, 0, 1'b0, 0, 1'b1);
      check("alternating_grant", 64'(model_last), 64'(j % 2));
    end
    req_valid = '0;
    tick();

    // Constant-time padding and its boundaries.
    run_job(2'b01, 1'b1, 50, 1'b0, 0, 1'b0);
    run_job(2'b10, 1'b1, 300, 1'b0, 0, 1'b0);
    run_job(2'b01, 1'b1, PAD, 1'b0, 0, 1'b0);
    run_job(2'b10, 1'b0, 1, 1'b0, 0, 1'b0);

    // Hung engine, then a normal job, then finish exactly at the timeout.
    run_job(2'b01, 1'b1, 0, 1'b1, 0, 1'b0);
    run_job(2'b10, 1'b0, 0, 1'b0, 0, 1'b0);
    run_job(2'b01, 1'b0, TIMEOUT, 1'b0, 0, 1'b0);

    // Response backpressure.
    run_job(2'b10, 1'b0, 0, 1'b0, 20, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 8; j++) begin
      logic [NREQ-1:0] vm;
      int lt;
      vm = NREQ'($urandom_range(1, 3));
      lt = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 250));
      run_job(vm, 1'($urandom_range(0, 1)), lt, 1'b0, int'($urandom_range(0, 4)), 1'b0);
    end

    // Reset in the middle of BUSY: job dropped, arbitration restarts at 0.
    run_job(2'b01, 1'b0, 5, 1'b0, 0, 1'b0);
    eng_hang  = 1'b1;
    req_valid = 2'b10;
    #1;
    n = 0;
    while (!(|(req_valid & req_ready)) && n < 20) begin
      tick();
      n++;
    end
    check("abort_job_accept", 64'(req_ready), 64'(oh(1)));
    tick();
    req_valid = '0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    check_all_zero("reset_mid_busy");
    rst = 1'b0;
    eng_hang = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (resp_valid != '0 || eng_start) seen++;
    end
    check("no_resp_after_abort", 64'(seen), 64'd0);
    model_last = NREQ - 1;
    run_job(2'b11, 1'b0, 0, 1'b0, 0, 1'b0);
    check("fresh_grant_req0", 64'(model_last), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
